// File: rtl/mem_port_arbiter.sv
// Two-master (inst fetch / data) arbiter onto a single memory port with one
// outstanding transaction, data priority with bounded inst starvation, and inst flush.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic        cancel_q, owner_inst;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        grant_inst, grant_data, inst_win, resp_done;

  assign inst_win = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE: begin
        // A flushing fetcher is never granted; data may take the slot instead.
        if (inst_req && !inst_cancel && (!data_req || inst_win)) grant_inst = 1'b1;
        else if (data_req)                                      grant_data = 1'b1;
        if (grant_inst || grant_data) state_nxt = ADDR;
      end
      ADDR:    if (mem_addr_ok) state_nxt = RESP;
      RESP:    if (mem_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  assign resp_done    = !reset && (state == RESP) && mem_data_ok;
  assign inst_data_ok = resp_done && owner_inst && !cancel_q && !inst_cancel;
  assign data_data_ok = resp_done && !owner_inst;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

  assign mem_req   = !reset && (state == ADDR);
  assign mem_wr    = reset ? 1'b0  : wr_q;
  assign mem_size  = reset ? 2'b0  : size_q;
  assign mem_addr  = reset ? 32'h0 : addr_q;
  assign mem_wstrb = reset ? 4'h0  : wstrb_q;
  assign mem_wdata = reset ? 32'h0 : wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      cancel_q   <= 1'b0;
      owner_inst <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'b0;
      addr_q     <= 32'h0;
      wstrb_q    <= 4'h0;
      wdata_q    <= 32'h0;
    end else begin
      state <= state_nxt;
      if (grant_inst) begin
        owner_inst <= 1'b1;
        wr_q       <= 1'b0;
        size_q     <= 2'd2;
        addr_q     <= inst_addr;
        wstrb_q    <= 4'h0;
        wdata_q    <= 32'h0;
        starve_cnt <= 4'd0;
      end else if (grant_data) begin
        owner_inst <= 1'b0;
        wr_q       <= data_wr;
        size_q     <= data_size;
        addr_q     <= data_addr;
        wstrb_q    <= data_wstrb;
        wdata_q    <= data_wdata;
        // Saturate so a long-cancelled fetcher cannot wrap the counter.
        if (!inst_req)                starve_cnt <= 4'd0;
        else if (starve_cnt != 4'hF)  starve_cnt <= starve_cnt + 4'd1;
      end
      if (state_nxt == IDLE)
        cancel_q <= 1'b0;
      else if (state != IDLE && owner_inst && inst_cancel)
        cancel_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: read, priority, starvation, cancel,
// backpressure and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From an IDLE cycle with requests already driven: record the grant, then
  // complete the transaction with zero-wait memory responses.
  task automatic txn(output logic gi, output logic gd);
    #1;
    gi = inst_addr_ok;
    gd = data_addr_ok;
    tick(); mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    tick(); mem_data_ok = 1'b0;
  endtask

  logic gi, gd;

  initial begin
    reset = 1'b1; inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

    // Reset: outputs held low even with requests present
    tick(); inst_req = 1'b1; data_req = 1'b1; mem_data_ok = 1'b1; #1;
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 0);
    chk("rst_mem_req",      32'(mem_req), 0);
    chk("rst_data_ok",      32'({inst_data_ok, data_data_ok}), 0);
    tick(); reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;

    // Single read
    tick(); inst_req = 1'b1; inst_addr = 32'h1C00_0000; #1;
    chk("rd_inst_addr_ok", 32'(inst_addr_ok), 1);
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b1; #1;
    chk("rd_mem_req",   32'(mem_req), 1);
    chk("rd_mem_addr",  mem_addr, 32'h1C00_0000);
    chk("rd_mem_wr",    32'(mem_wr), 0);
    chk("rd_mem_size",  32'(mem_size), 2);
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000; #1;
    chk("rd_inst_data_ok", 32'(inst_data_ok), 1);
    chk("rd_inst_rdata",   inst_rdata, 32'h0280_0000);
    chk("rd_mem_req_resp", 32'(mem_req), 0);
    tick(); mem_data_ok = 1'b0; #1;
    chk("rd_data_ok_drop", 32'(inst_data_ok), 0);
    chk("rd_rdata_zero",   inst_rdata, 0);

    // Priority: data write beats inst
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF; #1;
    chk("pri_data_granted", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
    tick(); data_req = 1'b0; mem_addr_ok = 1'b1; #1;
    chk("pri_mem_wr",    32'(mem_wr), 1);
    chk("pri_mem_wstrb", 32'(mem_wstrb), 32'hF);
    chk("pri_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("pri_mem_addr",  mem_addr, 32'h8000);
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
    chk("pri_data_data_ok", 32'(data_data_ok), 1);
    chk("pri_no_inst_grant", 32'(inst_addr_ok), 0);
    tick(); mem_data_ok = 1'b0; #1;
    chk("pri_inst_after", 32'(inst_addr_ok), 1);
    txn(gi, gd);

    // Starvation: D,D,D,D,I,D,D,D,D,I
    inst_req = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      txn(gi, gd);
      chk($sformatf("starve_inst_%0d", i), 32'(gi), 32'((i % 5) == 4));
      chk($sformatf("starve_data_%0d", i), 32'(gd), 32'((i % 5) != 4));
    end
    inst_req = 1'b0; data_req = 1'b0;

    // Cancel of an inst transaction in RESP
    tick(); inst_req = 1'b1; inst_addr = 32'h100; #1;
    chk("can_inst_addr_ok", 32'(inst_addr_ok), 1);
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; inst_cancel = 1'b1;
    tick(); inst_cancel = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_5555; #1;
    chk("can_inst_data_ok", 32'(inst_data_ok), 0);
    chk("can_inst_rdata",   inst_rdata, 0);
    chk("can_data_data_ok", 32'(data_data_ok), 0);
    tick(); mem_data_ok = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h40; #1;
    chk("can_next_data_grant", 32'(data_addr_ok), 1);
    tick(); data_req = 1'b0; mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; #1;
    chk("can_data_rdata", data_rdata, 32'h1234_5678);
    tick(); mem_data_ok = 1'b0;

    // Cancel held in IDLE: inst refused, data taken
    inst_req = 1'b1; inst_cancel = 1'b1; #1;
    chk("idle_cancel_refuse", 32'({inst_addr_ok, data_addr_ok}), 0);
    data_req = 1'b1; data_addr = 32'h44; #1;
    chk("idle_cancel_data", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
    gi = 1'b0;
    tick(); data_req = 1'b0; inst_cancel = 1'b0; mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
    chk("idle_cancel_data_ok", 32'(data_data_ok), 1);
    tick(); mem_data_ok = 1'b0; inst_req = 1'b0;

    // Backpressure: 5 cycles without mem_addr_ok
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h9000; data_wstrb = 4'h3;
    data_wdata = 32'hCAFE_F00D; #1;
    chk("bp_grant", 32'(data_addr_ok), 1);
    tick(); data_req = 1'b0; inst_req = 1'b1; data_addr = 32'h0; data_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_hold_%0d", i),
          {mem_req, mem_wr, mem_addr[15:0], mem_wdata[15:0] ^ {12'h0, mem_wstrb}},
          {1'b1, 1'b1, 16'h9000, 16'hF00D ^ 16'h0003});
      chk($sformatf("bp_addr_ok_%0d", i), 32'({inst_addr_ok, data_addr_ok}), 0);
      tick();
    end
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
    chk("bp_data_ok", 32'(data_data_ok), 1);
    tick(); mem_data_ok = 1'b0;

    // Reset in ADDR, then a stale mem_data_ok
    inst_req = 1'b1; inst_addr = 32'h2000;
    tick(); inst_req = 1'b0; #1;
    chk("rstm_in_addr", 32'(mem_req), 1);
    reset = 1'b1; #1;
    chk("rstm_outputs", {mem_req, mem_wr, mem_size, mem_wstrb, inst_addr_ok, data_addr_ok}, 0);
    chk("rstm_mem_addr", mem_addr, 0);
    tick(); reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5A5A_5A5A; #1;
    chk("rstm_stale_ok", 32'({inst_data_ok, data_data_ok}), 0);
    chk("rstm_rdata", inst_rdata | data_rdata, 0);
    tick(); mem_data_ok = 1'b0; #1;
    chk("rstm_idle_outs", {mem_req, mem_addr[29:0]}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data grants while inst is waiting; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have inst-master inputs inst_req (1 bit) and inst_addr (32 bits): read-only fetch request.
REQ-005 SHALL have inst-master outputs inst_addr_ok (1), inst_data_ok (1) and inst_rdata (32).
REQ-006 SHALL have input inst_cancel (1 bit): a flush pulse that discards the inst response in flight.
REQ-007 SHALL have data-master inputs data_req (1), data_wr (1), data_size (2), data_addr (32), data_wstrb (4) and data_wdata (32).
REQ-008 SHALL have data-master outputs data_addr_ok (1), data_data_ok (1) and data_rdata (32).
REQ-009 SHALL have shared-port outputs mem_req (1), mem_wr (1), mem_size (2), mem_addr (32), mem_wstrb (4) and mem_wdata (32).
REQ-010 SHALL have shared-port inputs mem_addr_ok (1), mem_data_ok (1) and mem_rdata (32).

Function
REQ-011 SHALL implement FSM states IDLE, ADDR and RESP, with at most one transaction outstanding on the shared port.
REQ-012 SHALL, in IDLE with a request present, grant one master and assert that master's addr_ok combinationally in the same cycle, latch its fields, and move to ADDR.
REQ-013 SHALL, for an inst grant, latch mem_wr=0, mem_size=2, mem_wstrb=0 and mem_wdata=0.
REQ-014 SHALL give data priority over inst when both request, except when starve_cnt==STARVE_LIMIT, in which case inst SHALL win.
REQ-015 SHALL keep a 4-bit starve_cnt updated on each grant as follows:
- +1 on a data grant while inst_req=1;
- cleared on a data grant while inst_req=0;
- cleared on an inst grant.
REQ-016 SHALL, in ADDR, hold mem_req=1 with the latched fields stable until mem_addr_ok=1, then move to RESP; mem_req SHALL be 0 in IDLE and RESP.
REQ-017 SHALL, in RESP on mem_data_ok=1, drive the owner's data_ok=1 and rdata=mem_rdata combinationally for one cycle, then return to IDLE.
REQ-018 SHALL keep a master's data_ok at 0 except in REQ-017; writes SHALL also complete via data_data_ok.
REQ-019 SHALL hold both addr_ok outputs at 0 outside IDLE, so no new grant occurs until the cycle after completion.
REQ-020 SHALL have a minimum latency of 2 cycles from addr_ok to data_ok, namely mem_addr_ok in the first ADDR cycle and mem_data_ok in the first RESP cycle.
REQ-021 SHALL drive inst_rdata and data_rdata to 0 whenever the corresponding data_ok is 0.
REQ-022 SHALL, in IDLE while inst_cancel=1, refuse the inst grant (inst_addr_ok=0); a pending data_req may be granted instead.
REQ-023 SHALL, on inst_cancel=1 while an inst transaction is in ADDR or RESP, set a cancel flag with the following effects:
- mem_req SHALL stay asserted until mem_addr_ok, with no withdrawal;
- the matching mem_data_ok SHALL be consumed with inst_data_ok=0;
- the FSM SHALL return to IDLE;
- the flag SHALL clear on return to IDLE.
REQ-024 SHALL leave data transactions unaffected by inst_cancel.
REQ-025 SHALL treat inst_cancel coincident with inst mem_data_ok in RESP as a cancel, suppressing that inst_data_ok.
REQ-026 SHALL ignore mem_data_ok in IDLE or ADDR and mem_addr_ok outside ADDR.

Reset
REQ-027 SHALL, while reset=1, force the following:
- state=IDLE, starve_cnt=0 and the cancel flag cleared;
- all latched fields cleared to 0;
- all outputs 0, including the addr_ok outputs, regardless of requests.
REQ-028 SHALL, on reset asserted mid-transaction, abandon the transaction without any data_ok, and SHALL ignore a later stale mem_data_ok (REQ-026).

Verification
REQ-029 SHALL pass the single read scenario: inst_req=1, inst_addr=0x1C000000 in cycle 0 -> inst_addr_ok=1 in cycle 0; mem_req=1, mem_addr=0x1C000000, mem_wr=0 in cycle 1; with mem_addr_ok in cycle 1 and mem_data_ok with rdata 0x02800000 in cycle 2 -> inst_data_ok=1 with 0x02800000 in cycle 2.
REQ-030 SHALL pass the priority scenario: inst_req and data_req held with a data write (addr 0x8000, wstrb 0xF, wdata 0xDEADBEEF) -> data is granted first and mem_wstrb=0xF; inst is granted in the IDLE after data_data_ok.
REQ-031 SHALL pass the starvation scenario: STARVE_LIMIT=4 with both requests held continuously -> the grant order is D,D,D,D,I,D,D,D,D,I.
REQ-032 SHALL pass the cancel scenario: inst transaction in RESP and inst_cancel pulsed, then mem_data_ok -> inst_data_ok stays 0, the FSM returns to IDLE, and a next data_req is granted normally.
REQ-033 SHALL pass the backpressure scenario: mem_addr_ok held 0 for 5 cycles -> mem_req and all mem_* fields stay stable for 5 cycles, and both addr_ok outputs stay 0.
REQ-034 SHALL pass the reset scenario: reset asserted in ADDR, then mem_data_ok pulsed after reset deasserts -> no data_ok, and all outputs are 0 until a new request.
